// File: rtl/tick_counter_pkg.sv
// Shared helpers for the tick_counter family of timing blocks.
//   clog2 : ceiling log2 of a positive value (clog2(1) = 0).
//   pre_w : prescaler counter width for a given divide ratio,
//           never narrower than one bit so DIV=1 still has a register.
package tick_counter_pkg;

  function automatic int clog2(input longint value);
    int r;
    r = 0;
    while ((longint'(1) << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int pre_w(input longint div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

endpackage

// File: rtl/tick_counter_if.sv
// Control/status bundle between a sequencing block and tick_counter.
//   en       : prescaler advances only while high
//   up       : 1 = count up, 0 = count down (sampled on step cycles)
//   load     : synchronous load of load_val (clamped to MODULUS-1)
//   load_val : value to load
//   count    : current registered count
//   tick     : one-cycle pulse, count just stepped
//   tc       : one-cycle pulse, a step hit a boundary (wrap or saturate)
// master drives the controls, slave is the counter itself.
interface tick_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;

  modport master (
    output en, up, load, load_val,
    input  count, tick, tc
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tick, tc
  );
endinterface

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: emits a one-cycle step every DIV enabled cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, clears the phase
//   en   : phase advances only while high; holds otherwise
//   clr  : synchronous phase clear (lower priority than rst)
//   step : combinational, high when en and the phase is at DIV-1
// With DIV=1 the phase register stays at 0 and step follows en.
module tick_prescaler
  import tick_counter_pkg::*;
#(
  parameter int DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int               PRE_W = pre_w(DIV);
  localparam logic [PRE_W-1:0] LAST  = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign step = en && (pre_cnt == LAST);

  // phase register: a disabled cycle freezes the phase, so a pause
  // stretches the current period instead of restarting it
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Modulus-N up/down counter advanced by a prescaled step enable.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, highest priority
//   bus : tick_counter_if slave (en, up, load, load_val in;
//         count, tick, tc out)
// Edge priority is rst > load > step > hold. A load clears the
// prescaler phase and swallows a coincident step. count, tick and tc
// are registered, so the pulses line up with the new count value.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int DIV      = 100000000,
  parameter int SATURATE = 0
) (
  input logic          clk,
  input logic          rst,
  tick_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             step_p0;
  logic [WIDTH-1:0] next_p0;
  logic             bound_p0;
  logic [WIDTH-1:0] count_p1;
  logic             vld_p1;
  logic             tc_p1;

  // out-of-range loads are pulled to the top of the range so the
  // count can never leave 0..MODULUS-1
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  // returns {boundary_hit, next_count}; at a boundary the count either
  // wraps to the opposite end or holds, depending on SATURATE
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                input logic             dir_up);
    logic             at_bound;
    logic [WIDTH-1:0] nxt;
    if (dir_up) begin
      at_bound = (cur == MAX);
      if (!at_bound)          nxt = cur + 1'b1;
      else if (SATURATE != 0) nxt = MAX;
      else                    nxt = '0;
    end else begin
      at_bound = (cur == '0);
      if (!at_bound)          nxt = cur - 1'b1;
      else if (SATURATE != 0) nxt = '0;
      else                    nxt = MAX;
    end
    return {at_bound, nxt};
  endfunction

  // stage 0: prescaler step and combinational next count
  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .step (step_p0)
  );

  always_comb begin
    {bound_p0, next_p0} = step_count(count_p1, bus.up);
  end

  // stage 1: registered count with its tick/tc pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1 <= '0;
      vld_p1   <= 1'b0;
      tc_p1    <= 1'b0;
    end else if (bus.load) begin
      count_p1 <= clamp_load(bus.load_val);
      vld_p1   <= 1'b0;
      tc_p1    <= 1'b0;
    end else if (step_p0) begin
      count_p1 <= next_p0;
      vld_p1   <= 1'b1;
      tc_p1    <= bound_p0;
    end else begin
      vld_p1   <= 1'b0;
      tc_p1    <= 1'b0;
    end
  end

  assign bus.count = count_p1;
  assign bus.tick  = vld_p1;
  assign bus.tc    = tc_p1;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter: three instances cover the wrap
// configuration (DIV=4), the saturating configuration (DIV=4) and the
// undivided configuration (DIV=1), all WIDTH=4, MODULUS=10.
module tb_tick_counter;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_s = 1'b1;
  logic rst_d = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tick_counter_if #(.WIDTH(4)) bus_a ();
  tick_counter_if #(.WIDTH(4)) bus_s ();
  tick_counter_if #(.WIDTH(4)) bus_d ();

  tick_counter #(.WIDTH(4), .MODULUS(10), .DIV(4), .SATURATE(0)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a.slave));
  tick_counter #(.WIDTH(4), .MODULUS(10), .DIV(4), .SATURATE(1)) dut_s (
    .clk (clk), .rst (rst_s), .bus (bus_s.slave));
  tick_counter #(.WIDTH(4), .MODULUS(10), .DIV(1), .SATURATE(0)) dut_d (
    .clk (clk), .rst (rst_d), .bus (bus_d.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_val = 4'd0;
    bus_s.en = 1'b0; bus_s.up = 1'b1; bus_s.load = 1'b0; bus_s.load_val = 4'd0;
    bus_d.en = 1'b0; bus_d.up = 1'b1; bus_d.load = 1'b0; bus_d.load_val = 4'd0;
    cyc();
    cyc();

    // reset state
    chk("rst_count", 32'(bus_a.count), 32'd0);
    chk("rst_tick",  32'(bus_a.tick),  32'd0);
    chk("rst_tc",    32'(bus_a.tc),    32'd0);

    // free count up: tick every 4th edge, one wrap with tc at the 10th tick
    rst_a = 1'b0;
    bus_a.en = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      cyc();
      chk("up_tick",  32'(bus_a.tick),  32'(k % 4 == 0));
      chk("up_count", 32'(bus_a.count), 32'((k / 4) % 10));
      chk("up_tc",    32'(bus_a.tc),    32'(k == 40));
    end

    // load 13 coincident with a step: clamps to 9, pulses suppressed
    cyc(); cyc(); cyc();
    bus_a.load = 1'b1;
    bus_a.load_val = 4'd13;
    cyc();
    bus_a.load = 1'b0;
    chk("ld_count", 32'(bus_a.count), 32'd9);
    chk("ld_tick",  32'(bus_a.tick),  32'd0);
    chk("ld_tc",    32'(bus_a.tc),    32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("ld_next_tick", 32'(bus_a.tick), 32'(k == 4));
    end
    chk("ld_wrap_count", 32'(bus_a.count), 32'd0);
    chk("ld_wrap_tc",    32'(bus_a.tc),    32'd1);

    // pause en for 5 cycles at phase 2: tick 5 cycles late, phase kept
    cyc(); cyc();
    chk("pause_pre_tick", 32'(bus_a.tick), 32'd0);
    bus_a.en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("pause_hold_tick", 32'(bus_a.tick), 32'd0);
    end
    bus_a.en = 1'b1;
    cyc();
    chk("pause_resume_tick", 32'(bus_a.tick), 32'd0);
    cyc();
    chk("pause_step_tick",  32'(bus_a.tick),  32'd1);
    chk("pause_step_count", 32'(bus_a.count), 32'd1);

    // count down from reset: 9 (tc), 8, 7
    rst_a = 1'b1;
    bus_a.en = 1'b0;
    bus_a.up = 1'b0;
    cyc();
    chk("dn_rst_count", 32'(bus_a.count), 32'd0);
    rst_a = 1'b0;
    bus_a.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("dn_tick",  32'(bus_a.tick),  32'(k % 4 == 0));
      chk("dn_count", 32'(bus_a.count), (k < 4) ? 32'd0 : 32'(10 - k / 4));
      chk("dn_tc",    32'(bus_a.tc),    32'(k == 4));
    end

    // saturate: load 8, then 9, 9, 9 with tc on the 2nd and 3rd steps
    rst_s = 1'b0;
    bus_s.load = 1'b1;
    bus_s.load_val = 4'd8;
    cyc();
    bus_s.load = 1'b0;
    chk("sat_ld_count", 32'(bus_s.count), 32'd8);
    bus_s.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("sat_tick",  32'(bus_s.tick),  32'(k % 4 == 0));
      chk("sat_count", 32'(bus_s.count), (k < 4) ? 32'd8 : 32'd9);
      chk("sat_tc",    32'(bus_s.tc),    32'(k == 8 || k == 12));
    end

    // DIV=1: step every cycle, reset at count 6, restart one cycle later
    rst_d = 1'b0;
    bus_d.en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("d1_count", 32'(bus_d.count), 32'(k));
      chk("d1_tick",  32'(bus_d.tick),  32'd1);
    end
    rst_d = 1'b1;
    cyc();
    chk("d1_rst_count", 32'(bus_d.count), 32'd0);
    chk("d1_rst_tick",  32'(bus_d.tick),  32'd0);
    chk("d1_rst_tc",    32'(bus_d.tc),    32'd0);
    rst_d = 1'b0;
    cyc();
    chk("d1_after_count", 32'(bus_d.count), 32'd1);
    chk("d1_after_tick",  32'(bus_d.tick),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
